// File: rtl/bar_height_smoother_if.sv
// Bar-height smoother bus: loader/frame-timing inputs and committed outputs
// toward the VGA bar renderer. The master side drives frame_end and new
// heights; the slave side (the smoother) returns the committed set.
interface bar_height_smoother_if #(
  parameter int NUM_BARS = 16,
  parameter int HEIGHT_W = 9
);
  logic                         frame_end;
  logic                         new_valid;
  logic [NUM_BARS*HEIGHT_W-1:0] new_heights;
  logic [NUM_BARS*HEIGHT_W-1:0] heights_out;
  logic [NUM_BARS*HEIGHT_W-1:0] peaks_out;
  logic                         out_valid;
  logic                         busy;

  modport master (
    output frame_end, new_valid, new_heights,
    input  heights_out, peaks_out, out_valid, busy
  );

  modport slave (
    input  frame_end, new_valid, new_heights,
    output heights_out, peaks_out, out_valid, busy
  );
endinterface

// File: rtl/bar_height_smoother.sv
// Per-frame bar-height smoother: instant attack, linear decay, optional
// peak-hold markers. Bars are processed serially one per cycle after
// frame_end, then the whole set is committed in one cycle so the renderer
// never sees a half-updated frame.
// Optional feature macro: BAR_PEAK_HOLD_EN (peak registers, hold counters,
// peaks_out). When undefined, peaks_out is constant 0.
module bar_height_smoother #(
  parameter int NUM_BARS         = 16,
  parameter int HEIGHT_W         = 9,
  parameter int MAX_HEIGHT       = 479,
  parameter int DECAY_STEP       = 4,
  parameter int PEAK_HOLD_FRAMES = 30
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  bar_height_smoother_if.slave   bus
);

  localparam int                  IDX_W    = $clog2(NUM_BARS);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_BARS - 1);
  localparam logic [HEIGHT_W-1:0] MAX_H    = HEIGHT_W'(MAX_HEIGHT);
  localparam logic [HEIGHT_W-1:0] STEP     = HEIGHT_W'(DECAY_STEP);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PROC   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  function automatic logic [HEIGHT_W-1:0] clamp_height(input logic [HEIGHT_W-1:0] v);
    return (v > MAX_H) ? MAX_H : v;
  endfunction

  // Attack is instant; decay falls by STEP but never undershoots the target.
  // The subtraction only happens once h > t is known, so it cannot wrap.
  function automatic logic [HEIGHT_W-1:0] smooth_height(input logic [HEIGHT_W-1:0] h,
                                                        input logic [HEIGHT_W-1:0] t);
    if (t >= h)
      return t;
    else if ((h - t) > STEP)
      return h - STEP;
    else
      return t;
  endfunction

  logic [1:0]                   state;
  logic [IDX_W-1:0]             idx;
  logic [HEIGHT_W-1:0]          staging  [NUM_BARS];
  logic [HEIGHT_W-1:0]          snapshot [NUM_BARS];
  logic [HEIGHT_W-1:0]          working  [NUM_BARS];
  logic [NUM_BARS*HEIGHT_W-1:0] heights_q;
  logic                         out_valid_q;
  logic [HEIGHT_W-1:0]          tgt;
  logic [HEIGHT_W-1:0]          h_new;

  // Smoothed height of the bar currently being processed
  always_comb begin
    tgt   = clamp_height(snapshot[idx]);
    h_new = smooth_height(working[idx], tgt);
  end

  // Staging buffer: latest loader write wins, accepted in any state
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARS; i++) staging[i] <= '0;
    end else if (bus.new_valid) begin
      for (int i = 0; i < NUM_BARS; i++)
        staging[i] <= bus.new_heights[i*HEIGHT_W +: HEIGHT_W];
    end
  end

  // Sequencer: snapshot on frame_end, one bar per cycle, then commit
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      out_valid_q <= 1'b0;
      heights_q   <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        snapshot[i] <= '0;
        working[i]  <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.frame_end) begin
            // A loader write coincident with frame_end bypasses staging
            for (int i = 0; i < NUM_BARS; i++)
              snapshot[i] <= bus.new_valid ? bus.new_heights[i*HEIGHT_W +: HEIGHT_W]
                                           : staging[i];
            idx   <= '0;
            state <= S_PROC;
          end
        end
        S_PROC: begin
          working[idx] <= h_new;
          if (idx == LAST_IDX) state <= S_COMMIT;
          else                 idx   <= idx + 1'b1;
        end
        S_COMMIT: begin
          for (int i = 0; i < NUM_BARS; i++)
            heights_q[i*HEIGHT_W +: HEIGHT_W] <= working[i];
          out_valid_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BAR_PEAK_HOLD_EN
  localparam int                HOLD_W    = $clog2(PEAK_HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(PEAK_HOLD_FRAMES);

  logic [HEIGHT_W-1:0]          peak [NUM_BARS];
  logic [HOLD_W-1:0]            hold [NUM_BARS];
  logic [NUM_BARS*HEIGHT_W-1:0] peaks_q;
  logic [HEIGHT_W-1:0]          peak_dec;

  // One-step peak fall; only used when peak > h_new, so peak >= 1
  always_comb peak_dec = peak[idx] - HEIGHT_W'(1);

  // Peak-hold tracking alongside the height update, committed with heights
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      peaks_q <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        peak[i] <= '0;
        hold[i] <= '0;
      end
    end else if (state == S_PROC) begin
      if (h_new >= peak[idx]) begin
        peak[idx] <= h_new;
        hold[idx] <= HOLD_INIT;
      end else if (hold[idx] != '0) begin
        hold[idx] <= hold[idx] - 1'b1;
      end else begin
        peak[idx] <= (peak_dec > h_new) ? peak_dec : h_new;
      end
    end else if (state == S_COMMIT) begin
      for (int i = 0; i < NUM_BARS; i++)
        peaks_q[i*HEIGHT_W +: HEIGHT_W] <= peak[i];
    end
  end

  assign bus.peaks_out = peaks_q;
`else
  // Hold length only matters when peaks are built; keep it referenced
  logic unused_hold_cfg;
  assign unused_hold_cfg = (PEAK_HOLD_FRAMES != 0);
  assign bus.peaks_out   = '0;
`endif

  assign bus.heights_out = heights_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_bar_height_smoother.sv
// Directed bench for bar_height_smoother at default parameters. Peak
// expectations follow BAR_PEAK_HOLD_EN: zero when the macro is undefined.
module tb_bar_height_smoother;
  localparam int NB = 16;
  localparam int HW = 9;
`ifdef BAR_PEAK_HOLD_EN
  localparam bit PEAKS_ON = 1'b1;
`else
  localparam bit PEAKS_ON = 1'b0;
`endif

  logic CLOCK_50;
  logic reset;
  int   compared;
  int   mismatched;

  bar_height_smoother_if #(.NUM_BARS(NB), .HEIGHT_W(HW)) bus ();

  bar_height_smoother dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bar_of(input logic [NB*HW-1:0] v, input int i);
    return 32'(v[i*HW +: HW]);
  endfunction

  function automatic logic [31:0] pk(input int v);
    return PEAKS_ON ? 32'(v) : 32'd0;
  endfunction

  // Wait (bounded) for out_valid; lat counts cycles from the current point
  task automatic wait_commit(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_frame(output int lat);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    wait_commit(lat);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [NB*HW-1:0] cap;
    int eh0;

    compared    = 0;
    mismatched  = 0;
    reset       = 1'b1;
    bus.frame_end   = 1'b1;
    bus.new_valid   = 1'b1;
    bus.new_heights = '1;

    // Reset with stimulus toggling
    tick();
    bus.frame_end = 1'b0;
    bus.new_valid = 1'b0;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_h0", bar_of(bus.heights_out, 0), 0);
    chk("rst_h15", bar_of(bus.heights_out, 15), 0);
    chk("rst_p0", bar_of(bus.peaks_out, 0), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);

    // Attack: bar0=100, bar15=479
    bus.new_heights = '0;
    bus.new_heights[0*HW +: HW]  = 9'd100;
    bus.new_heights[15*HW +: HW] = 9'd479;
    bus.new_valid = 1'b1;
    tick();
    bus.new_valid = 1'b0;
    tick();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    chk("attack_busy_start", 32'(bus.busy), 1);
    wait_commit(lat);
    chk("attack_latency", 32'(lat), 17);
    chk("attack_busy_end", 32'(bus.busy), 0);
    chk("attack_h0", bar_of(bus.heights_out, 0), 100);
    chk("attack_h1", bar_of(bus.heights_out, 1), 0);
    chk("attack_h15", bar_of(bus.heights_out, 15), 479);
    chk("attack_p0", bar_of(bus.peaks_out, 0), pk(100));
    chk("attack_p15", bar_of(bus.peaks_out, 15), pk(479));
    tick();
    chk("attack_pulse_width", 32'(bus.out_valid), 0);

    // Decay and peak hold: targets all 0
    bus.new_heights = '0;
    bus.new_valid = 1'b1;
    tick();
    bus.new_valid = 1'b0;
    for (int f = 1; f <= 32; f++) begin
      run_frame(lat);
      eh0 = (100 - 4*f > 0) ? 100 - 4*f : 0;
      chk($sformatf("decay_lat_f%0d", f), 32'(lat), 17);
      chk($sformatf("decay_h0_f%0d", f), bar_of(bus.heights_out, 0), 32'(eh0));
      chk($sformatf("decay_h15_f%0d", f), bar_of(bus.heights_out, 15), 32'(479 - 4*f));
      chk($sformatf("hold_p0_f%0d", f), bar_of(bus.peaks_out, 0),
          pk((f <= 30) ? 100 : 130 - f));
      chk($sformatf("hold_p15_f%0d", f), bar_of(bus.peaks_out, 15),
          pk((f <= 30) ? 479 : 509 - f));
      tick();
    end

    // Clamp with bypass: bar3=511 written in the frame_end cycle
    bus.new_heights = '0;
    bus.new_heights[3*HW +: HW] = 9'd511;
    bus.new_valid = 1'b1;
    bus.frame_end = 1'b1;
    tick();
    bus.new_valid = 1'b0;
    bus.frame_end = 1'b0;
    wait_commit(lat);
    chk("clamp_lat", 32'(lat), 17);
    chk("clamp_h3", bar_of(bus.heights_out, 3), 479);
    chk("clamp_h15", bar_of(bus.heights_out, 15), 347);
    chk("clamp_p3", bar_of(bus.peaks_out, 3), pk(479));
    tick();

    // Busy collisions: frame_end and a loader write during PROC
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    pulses = 0;
    lat    = 0;
    cap    = '0;
    for (int c = 1; c <= 40; c++) begin
      bus.frame_end = (c == 5);
      bus.new_valid = (c == 6);
      bus.new_heights = '0;
      bus.new_heights[0*HW +: HW] = 9'd200;
      tick();
      if (bus.out_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          lat = c;
          cap = bus.heights_out;
        end
      end
    end
    bus.frame_end = 1'b0;
    bus.new_valid = 1'b0;
    chk("collide_pulses", 32'(pulses), 1);
    chk("collide_lat", 32'(lat), 17);
    chk("collide_h0", bar_of(cap, 0), 0);
    chk("collide_h3", bar_of(cap, 3), 479);
    chk("collide_h15", bar_of(cap, 15), 343);
    run_frame(lat);
    chk("next_lat", 32'(lat), 17);
    chk("next_h0", bar_of(bus.heights_out, 0), 200);
    chk("next_h3", bar_of(bus.heights_out, 3), 475);
    chk("next_h15", bar_of(bus.heights_out, 15), 339);
    chk("next_p0", bar_of(bus.peaks_out, 0), pk(200));
    tick();

    // Reset mid-processing aborts without a commit
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_h0", bar_of(bus.heights_out, 0), 0);
    chk("abort_h3", bar_of(bus.heights_out, 3), 0);
    chk("abort_p0", bar_of(bus.peaks_out, 0), 0);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.out_valid === 1'b1) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
